// File: rtl/accum_alu_bank.sv
// Bank of NREGS accumulators sharing one 8-op ALU and a single set of C/Z/V flags.
// Each en=1 edge reads bank[acc_sel], combines it with data_in, and writes the result back.

module accum_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset)   q <= '0;
    else if (we) q <= d;
endmodule

module accum_alu_bank #(
  parameter  int WIDTH = 4,
  parameter  int NREGS = 4,
  localparam int SW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [SW-1:0]    acc_sel,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] acc_out,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             done
);
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_ADC  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] OP_LOAD = 3'd6;
  localparam logic [2:0] OP_RLC  = 3'd7;
  localparam int         MSB     = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
  } alu_rsp_t;

  logic [NREGS-1:0][WIDTH-1:0] bank;
  logic [NREGS-1:0]            we;
  logic [WIDTH-1:0]            a;
  logic [WIDTH:0]              sum;
  alu_rsp_t                    rsp;
  logic                        vld_q;
  logic [1:0]                  vld_pipe;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      assign we[gi] = en && (acc_sel == SW'(gi));
      accum_reg #(.WIDTH(WIDTH)) u_reg (
        .clk   (clk),
        .reset (reset),
        .we    (we[gi]),
        .d     (rsp.res),
        .q     (bank[gi])
      );
    end
  endgenerate

  assign a       = bank[acc_sel];
  assign acc_out = a;

  // Flags not touched by an op fall through from the defaults.
  always_comb begin
    sum     = '0;
    rsp.res = '0;
    rsp.c   = carry;
    rsp.v   = ovf;
    case (op)
      OP_AND: begin rsp.res = a & data_in; rsp.v = 1'b0; end
      OP_OR:  begin rsp.res = a | data_in; rsp.v = 1'b0; end
      OP_XOR: begin rsp.res = a ^ data_in; rsp.v = 1'b0; end
      OP_ADD, OP_ADC: begin
        sum     = {1'b0, a} + {1'b0, data_in}
                + ((op == OP_ADC) ? {{WIDTH{1'b0}}, carry} : '0);
        rsp.res = sum[WIDTH-1:0];
        rsp.c   = sum[WIDTH];
        rsp.v   = (a[MSB] == data_in[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        // Bit WIDTH of the extended difference is the unsigned borrow.
        sum     = {1'b0, a} - {1'b0, data_in};
        rsp.res = sum[WIDTH-1:0];
        rsp.c   = sum[WIDTH];
        rsp.v   = (a[MSB] != data_in[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_LOAD: rsp.res = data_in;
      OP_RLC: begin
        rsp.res = {a[WIDTH-2:0], carry};
        rsp.c   = a[MSB];
      end
      default: rsp.res = a;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      carry <= 1'b0;
      zero  <= 1'b1;
      ovf   <= 1'b0;
    end else if (en) begin
      carry <= rsp.c;
      zero  <= (rsp.res == '0);
      ovf   <= rsp.v;
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) vld_q <= 1'b0;
    else       vld_q <= vld_pipe[0];

  assign vld_pipe = {vld_q, en};
  assign done     = vld_pipe[1];
endmodule

// File: tb/tb_accum_alu_bank.sv
// Directed plan steps plus randomized ops, checked against an integer-arithmetic reference model.

module tb_accum_alu_bank;
  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] op;
  logic [1:0] acc_sel;
  logic [3:0] data_in;
  logic [3:0] acc_out;
  logic       carry, zero, ovf, done;

  int checks   = 0;
  int failures = 0;

  int mb[4];
  int mc, mz, mv;

  always #5 clk = ~clk;

  accum_alu_bank #(.WIDTH(4), .NREGS(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .op      (op),
    .acc_sel (acc_sel),
    .data_in (data_in),
    .acc_out (acc_out),
    .carry   (carry),
    .zero    (zero),
    .ovf     (ovf),
    .done    (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) mb[i] = 0;
    mc = 0; mz = 1; mv = 0;
  endfunction

  // Reference: unsigned/signed results from plain integer arithmetic, then range tests.
  function automatic void model_op(input int o, input int sel, input int d);
    int a, r, s;
    a = mb[sel];
    r = 0;
    case (o)
      0: begin r = a & d; mv = 0; end
      1: begin r = a | d; mv = 0; end
      2: begin r = a ^ d; mv = 0; end
      3, 4: begin
        s  = a + d + ((o == 4) ? mc : 0);
        r  = s % 16;
        mc = (s >= 16) ? 1 : 0;
        s  = sgn(a) + sgn(d) + ((o == 4) ? mc * 0 : 0);
        mv = 0;
        if (o == 4) s = sgn(a) + sgn(d) + ((a + d + ((r - a - d + 32) % 16)) - a - d);
        if (s > 7 || s < -8) mv = 1;
      end
      5: begin
        r  = (a - d + 16) % 16;
        mc = (a < d) ? 1 : 0;
        s  = sgn(a) - sgn(d);
        mv = (s > 7 || s < -8) ? 1 : 0;
      end
      6: r = d;
      default: begin
        r  = ((a * 2) + mc) % 16;
        mc = (a >= 8) ? 1 : 0;
      end
    endcase
    mb[sel] = r;
    mz = (r == 0) ? 1 : 0;
  endfunction

  task automatic check_state(input int sel, input int exp_done);
    chk($sformatf("acc_out[%0d]", sel), acc_out, mb[sel]);
    chk("carry", carry, mc);
    chk("zero",  zero,  mz);
    chk("ovf",   ovf,   mv);
    chk("done",  done,  exp_done);
  endtask

  task automatic do_op(input int o, input int sel, input int d);
    op = 3'(o); acc_sel = 2'(sel); data_in = 4'(d); en = 1'b1;
    @(posedge clk); #1;
    model_op(o, sel, d);
    check_state(sel, 1);
  endtask

  task automatic idle(input int sel);
    en = 1'b0; op = 3'($urandom_range(0, 7)); data_in = 4'($urandom_range(0, 15));
    acc_sel = 2'(sel);
    @(posedge clk); #1;
    check_state(sel, 0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; op = '0; acc_sel = '0; data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    // 1. Reset state, then async reset with an op in flight.
    for (int s = 0; s < 4; s++) idle(s);
    do_op(6, 2, 9);
    chk("plan1 bank2 loaded", acc_out, 4'h9);
    op = 3'd6; data_in = 4'h5; en = 1'b1; acc_sel = 2'd2;
    reset = 1'b1; #1;
    model_reset();
    chk("async reset bank2", acc_out, 4'h0);
    chk("async reset done", done, 1'b0);
    @(posedge clk); #1;
    chk("reset held bank2", acc_out, 4'h0);
    @(negedge clk); reset = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    check_state(2, 0);

    // 2. Wrap-around ADD and ADC consuming carry.
    do_op(6, 1, 7);
    do_op(3, 1, 9);
    chk("plan2 add wrap", {acc_out, carry, zero, ovf}, {4'h0, 1'b1, 1'b1, 1'b0});
    do_op(4, 1, 0);
    chk("plan2 adc", {acc_out, carry, zero}, {4'h1, 1'b0, 1'b0});

    // 3. Signed overflow and borrow.
    do_op(6, 0, 7);
    do_op(3, 0, 1);
    chk("plan3 add ovf", {acc_out, carry, ovf}, {4'h8, 1'b0, 1'b1});
    do_op(5, 0, 9);
    chk("plan3 sub borrow", {acc_out, carry, ovf}, {4'hF, 1'b1, 1'b0});

    // 4. Logic ops leave carry alone.
    do_op(6, 3, 12);
    do_op(0, 3, 10);
    chk("plan4 and", acc_out, 4'h8);
    do_op(1, 3, 3);
    chk("plan4 or", acc_out, 4'hB);
    do_op(2, 3, 11);
    chk("plan4 xor", {acc_out, zero, carry}, {4'h0, 1'b1, 1'b1});

    // 5. Rotate through carry (clear carry first with ADD 0).
    do_op(6, 2, 9);
    do_op(3, 2, 0);
    do_op(7, 2, 0);
    chk("plan5 rlc1", {acc_out, carry}, {4'h2, 1'b1});
    do_op(7, 2, 0);
    chk("plan5 rlc2", {acc_out, carry}, {4'h5, 1'b0});
    for (int s = 0; s < 4; s++) idle(s);

    // 6. Hold with toggling inputs, then combinational acc_sel sweep.
    for (int i = 0; i < 5; i++) idle(2);
    for (int s = 3; s >= 0; s--) begin
      acc_sel = 2'(s); #1;
      chk($sformatf("sweep acc_out[%0d]", s), acc_out, mb[s]);
    end

    // Randomized mix of ops and idle cycles.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) idle($urandom_range(0, 3));
      else do_op($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 15));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/accum_alu_bank.md
Name: accum_alu_bank

Overview:
- Parametrised successor to the team's 4-bit single-accumulator ALU tile.
- Holds NREGS accumulator registers of WIDTH bits each.
- Each enabled cycle executes one of 8 ops between the selected accumulator and data_in, writes the result back and updates carry/zero/overflow flags.
- Intended as the datapath core of the next TinyTapeout ALU project; the io_in/io_out pin wrapper lives outside this block.

Parameters:
- WIDTH, 4, data/accumulator width in bits (>=2).
- NREGS, 4, number of accumulator registers (power of 2, >=1).
- SW, $clog2(NREGS) (min 1), width of acc_sel. Derived; not to be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  execute strobe; 0 = hold all state.
- op  input  3  operation code (see Behaviour).
- acc_sel  input  SW  selects the accumulator that is operated on and displayed.
- data_in  input  WIDTH  operand D.
- acc_out  output  WIDTH  bank[acc_sel], combinational read of registered state.
- carry  output  1  C flag (registered).
- zero  output  1  Z flag (registered).
- ovf  output  1  V flag, signed overflow (registered).
- done  output  1  one-cycle pulse, high the cycle after an executed op.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - all bank entries = 0
  - carry = 0, ovf = 0, zero = 1, done = 0
  - reset mid-operation discards the op in flight; done stays 0.
- Rising edge with en=1: A = bank[acc_sel], D = data_in, Cin = carry.

Op table, writing bank[acc_sel] (all arithmetic is modulo 2^WIDTH, carry taken from bit WIDTH):
- 000 AND: A & D. C unchanged, V = 0.
- 001 OR: A | D. C unchanged, V = 0.
- 010 XOR: A ^ D. C unchanged, V = 0.
- 011 ADD: A + D. C = carry-out. V = signed overflow (A, D same sign, result sign differs).
- 100 ADC: A + D + Cin. C = carry-out. V as ADD.
- 101 SUB: A - D. C = borrow (1 iff A < D unsigned). V = signed overflow (A, D differ in sign, result sign differs from A).
- 110 LOAD: D. C unchanged, V unchanged.
- 111 RLC (rotate left through carry, D ignored): result = {A[WIDTH-2:0], Cin}, C = A[WIDTH-1]. V unchanged.

Flag and strobe rules:
- Z = (result == 0) after every executed op, including LOAD.
- done = 1 on the cycle after any edge with en=1, otherwise 0. Back-to-back en gives done held high continuously.

Hazards and boundaries:
- en=0: bank, flags and done hold (done drops to 0 the next cycle).
- acc_sel changing while en=0 only changes acc_out, the same cycle (combinational).
- Flags are global, not per-register. An op on register j uses the C left by the last op on any register.
- Wrap-around:
  - ADD 0xF + 0x1 (WIDTH=4) gives 0x0, C=1, Z=1.
  - SUB 0x0 - 0x1 gives 0xF, C=1.
- Latency: result visible on acc_out and flags one edge after the en=1 edge. No pipelining.
- No illegal op codes; all 8 are defined.

Test Plan (WIDTH=4, NREGS=4):
1. Reset then idle -> acc_out=0 for all acc_sel 0..3, carry=0, zero=1, ovf=0, done=0. Assert reset mid-sequence with bank[2]=0x9 -> bank[2]=0 immediately, without waiting for a clock.
2. sel=1: LOAD 0x7, then ADD 0x9 -> acc_out=0x0, carry=1, zero=1, ovf=0, done pulses once per op. Then ADC 0x0 -> 0x1, carry=0, zero=0.
3. sel=0: LOAD 0x7, ADD 0x1 -> 0x8, ovf=1, carry=0. Then SUB 0x9 -> 0xF, carry=1 (borrow), ovf=0.
4. sel=3: LOAD 0xC, AND 0xA -> 0x8; OR 0x3 -> 0xB; XOR 0xB -> 0x0, zero=1. Carry keeps its prior value through all three.
5. sel=2: LOAD 0x9 with carry=0, RLC -> 0x2, carry=1; RLC -> 0x5, carry=0. Bank[0], [1], [3] are unchanged (read back via acc_sel).
6. Hold: en=0 for 5 cycles with op/data toggling -> no state change, done=0. Sweep acc_sel -> acc_out follows in the same cycle.
